dist_ram_fifo_ctrl: RTL and testbench
=====================================

DIST_RAM_FIFO_CTRL -- requirements
Module: dist_ram_fifo_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 4, log2 of FIFO depth; DEPTH = 2**ADDR_WIDTH.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, entry width in bits.
REQ-003 SHALL have parameter ALMOST_FULL_THRESH, default DEPTH-2, count at or above which almost-full asserts.
REQ-004 SHALL have parameter ALMOST_EMPTY_THRESH, default 2, count at or below which almost-empty asserts.
REQ-005 SHALL have port i_clk  input  1  single clock; all state changes on its rising edge.
REQ-006 SHALL have port i_rst_n  input  1  reset; one clock, reset is synchronous and active-low.
REQ-007 SHALL have port i_wr_valid  input  1  producer offers i_wr_data.
REQ-008 SHALL have port o_wr_ready  output  1  FIFO can accept a write.
REQ-009 SHALL have port i_wr_data  input  DATA_WIDTH  write payload.
REQ-010 SHALL have port o_rd_valid  output  1  o_rd_data holds the head entry.
REQ-011 SHALL have port i_rd_ready  input  1  consumer takes the head entry.
REQ-012 SHALL have port o_rd_data  output  DATA_WIDTH  head entry (first-word fall-through).
REQ-013 SHALL have port o_count  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
REQ-014 SHALL have ports o_full, o_empty  output  1 each  status flags.
REQ-015 SHALL have ports o_almost_full, o_almost_empty  output  1 each  threshold flags (see Configuration).

Function
REQ-016 SHALL store entries in one internal sdp_dist_ram instance (ADDR_WIDTH, DATA_WIDTH); write port driven by the write pointer, read port by the read pointer.
REQ-017 SHALL keep write and read pointers of ADDR_WIDTH+1 bits; low bits address the RAM, MSB is the wrap bit; pointers increment modulo 2**(ADDR_WIDTH+1).
REQ-018 SHALL accept a write when i_wr_valid && o_wr_ready; RAM write enable equals that term; write pointer increments at that edge.
REQ-019 SHALL pop when o_rd_valid && i_rd_ready; read pointer increments at that edge.
REQ-020 SHALL drive o_wr_ready = !o_full and o_rd_valid = !o_empty, both from registered state only (no combinational path from i_rd_ready or i_wr_valid).
REQ-021 SHALL present o_rd_data combinationally from the RAM at the read pointer; value is don't-care while o_rd_valid=0.
REQ-022 SHALL make a write into an empty FIFO visible on o_rd_data with o_rd_valid=1 exactly one cycle after the accepting edge.
REQ-023 SHALL run a registered 3-state status FSM: EMPTY (count 0), ACTIVE (1..DEPTH-1), FULL (count DEPTH); o_empty=(state==EMPTY), o_full=(state==FULL).
REQ-024 SHALL transition: EMPTY->ACTIVE on push; ACTIVE->EMPTY on pop-only with count 1; ACTIVE->FULL on push-only with count DEPTH-1; FULL->ACTIVE on pop; otherwise hold.
REQ-025 SHALL, on simultaneous push and pop in ACTIVE, leave count and state unchanged and advance both pointers.
REQ-026 SHALL not push when FULL (ready low) and not pop when EMPTY (valid low), even if the partner side is active the same cycle.
REQ-027 SHALL update o_count registered: +1 push-only, -1 pop-only, unchanged otherwise; never exceed DEPTH or go below 0.

Reset
REQ-028 SHALL, while i_rst_n=0 at a rising edge, set both pointers 0, o_count 0, state EMPTY, o_empty=1, o_full=0, o_wr_ready=1, o_rd_valid=0, o_almost_empty=1, o_almost_full=0.
REQ-029 SHALL, on reset mid-operation, discard all stored entries and ignore any write or pop offered in the reset cycle; RAM contents are not cleared.

Configuration
REQ-030 SHALL compile almost flags only when macro DIST_RAM_FIFO_ALMOST_FLAGS_EN is defined: o_almost_full=(count>=ALMOST_FULL_THRESH), o_almost_empty=(count<=ALMOST_EMPTY_THRESH), both registered and updated with o_count.
REQ-031 SHALL, without DIST_RAM_FIFO_ALMOST_FLAGS_EN, tie o_almost_full=o_full and o_almost_empty=o_empty and omit threshold logic.

Verification
REQ-032 Reset then idle -> o_empty=1, o_wr_ready=1, o_rd_valid=0, o_count=0.
REQ-033 DEPTH=16: write 0x00..0x0F back-to-back, no reads -> o_full=1 after 16th edge, o_wr_ready=0, 17th write (0xFF) ignored; then drain -> reads return 0x00..0x0F in order, o_empty=1 after 16 pops.
REQ-034 Empty FIFO, single write 0xA5A5A5A5 -> next cycle o_rd_valid=1, o_rd_data=0xA5A5A5A5, o_count=1.
REQ-035 count=8, simultaneous push and pop for 40 cycles with incrementing data -> o_count stays 8, pointers wrap, data order preserved.
REQ-036 count=5, assert i_rst_n=0 for one cycle with i_wr_valid=1 -> o_count=0, o_empty=1, no entry written.
REQ-037 With DIST_RAM_FIFO_ALMOST_FLAGS_EN, fill to 14 -> o_almost_full=1 at count 14; drain to 2 -> o_almost_empty=1; without the macro, flags mirror o_full/o_empty.

Source files
------------

// File: rtl/dist_ram_fifo_ctrl.sv
// First-word fall-through FIFO controller over a simple dual-port distributed RAM.
// Define DIST_RAM_FIFO_ALMOST_FLAGS_EN to get registered threshold almost-full/almost-empty flags.

module sdp_dist_ram #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

module dist_ram_fifo_ctrl #(
  parameter int ADDR_WIDTH          = 4,
  parameter int DATA_WIDTH          = 32,
  parameter int ALMOST_FULL_THRESH  = 2**ADDR_WIDTH - 2,
  parameter int ALMOST_EMPTY_THRESH = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_wr_valid,
  output logic                  o_wr_ready,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  output logic                  o_rd_valid,
  input  logic                  i_rd_ready,
  output logic [DATA_WIDTH-1:0] o_rd_data,
  output logic [ADDR_WIDTH:0]   o_count,
  output logic                  o_full,
  output logic                  o_empty,
  output logic                  o_almost_full,
  output logic                  o_almost_empty
);
  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] CNT_ONE     = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH:0] CNT_FULL_M1 = (ADDR_WIDTH+1)'(DEPTH-1);

  typedef enum logic [1:0] {S_EMPTY, S_ACTIVE, S_FULL} state_t;

  state_t                state, state_next;
  logic [ADDR_WIDTH:0]   wr_ptr, rd_ptr, count, count_next;
  logic                  push, pop;

  // Handshake terms come only from registered state, so ready/valid never
  // depend combinationally on the partner side.
  assign o_empty    = (state == S_EMPTY);
  assign o_full     = (state == S_FULL);
  assign o_wr_ready = !o_full;
  assign o_rd_valid = !o_empty;
  assign push       = i_wr_valid && o_wr_ready;
  assign pop        = o_rd_valid && i_rd_ready;
  assign o_count    = count;

  sdp_dist_ram #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_ram (
    .clk   (i_clk),
    .we    (push),
    .waddr (wr_ptr[ADDR_WIDTH-1:0]),
    .wdata (i_wr_data),
    .raddr (rd_ptr[ADDR_WIDTH-1:0]),
    .rdata (o_rd_data)
  );

  always_comb begin
    count_next = count;
    if (push && !pop)      count_next = count + CNT_ONE;
    else if (pop && !push) count_next = count - CNT_ONE;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_EMPTY:  if (push) state_next = S_ACTIVE;
      S_ACTIVE: begin
        if (push && !pop && count == CNT_FULL_M1) state_next = S_FULL;
        else if (pop && !push && count == CNT_ONE) state_next = S_EMPTY;
      end
      S_FULL:   if (pop) state_next = S_ACTIVE;
      default:  state_next = S_EMPTY;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state  <= S_EMPTY;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      state  <= state_next;
      count  <= count_next;
      if (push) wr_ptr <= wr_ptr + CNT_ONE;
      if (pop)  rd_ptr <= rd_ptr + CNT_ONE;
    end
  end

`ifdef DIST_RAM_FIFO_ALMOST_FLAGS_EN
  localparam logic [ADDR_WIDTH:0] AF_T = (ADDR_WIDTH+1)'(ALMOST_FULL_THRESH);
  localparam logic [ADDR_WIDTH:0] AE_T = (ADDR_WIDTH+1)'(ALMOST_EMPTY_THRESH);

  // Flags track count_next so they change on the same edge as o_count.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_almost_full  <= 1'b0;
      o_almost_empty <= 1'b1;
    end else begin
      o_almost_full  <= (count_next >= AF_T);
      o_almost_empty <= (count_next <= AE_T);
    end
  end
`else
  assign o_almost_full  = o_full;
  assign o_almost_empty = o_empty;
`endif
endmodule

// File: tb/tb_dist_ram_fifo_ctrl.sv
// Directed bench for dist_ram_fifo_ctrl (DEPTH=16, 32-bit): fill/drain, FWFT latency,
// steady push+pop with wrap, mid-operation reset, and almost-flag thresholds.
module tb_dist_ram_fifo_ctrl;
  localparam int AW = 4;
  localparam int DW = 32;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr_valid;
  logic          wr_ready;
  logic [DW-1:0] wr_data;
  logic          rd_valid;
  logic          rd_ready;
  logic [DW-1:0] rd_data;
  logic [AW:0]   count;
  logic          full, empty, almost_full, almost_empty;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  dist_ram_fifo_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_wr_valid     (wr_valid),
    .o_wr_ready     (wr_ready),
    .i_wr_data      (wr_data),
    .o_rd_valid     (rd_valid),
    .i_rd_ready     (rd_ready),
    .o_rd_data      (rd_data),
    .o_count        (count),
    .o_full         (full),
    .o_empty        (empty),
    .o_almost_full  (almost_full),
    .o_almost_empty (almost_empty)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after an edge; outputs are checked there too.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic af_exp(input int c);
`ifdef DIST_RAM_FIFO_ALMOST_FLAGS_EN
    return (c >= DEPTH - 2);
`else
    return (c == DEPTH);
`endif
  endfunction

  function automatic logic ae_exp(input int c);
`ifdef DIST_RAM_FIFO_ALMOST_FLAGS_EN
    return (c <= 2);
`else
    return (c == 0);
`endif
  endfunction

  task automatic chk_status(input string tag, input int c);
    chk({tag, ".count"}, 64'(count), 64'(c));
    chk({tag, ".empty"}, 64'(empty), 64'(c == 0));
    chk({tag, ".full"}, 64'(full), 64'(c == DEPTH));
    chk({tag, ".wr_ready"}, 64'(wr_ready), 64'(c != DEPTH));
    chk({tag, ".rd_valid"}, 64'(rd_valid), 64'(c != 0));
    chk({tag, ".almost_full"}, 64'(almost_full), 64'(af_exp(c)));
    chk({tag, ".almost_empty"}, 64'(almost_empty), 64'(ae_exp(c)));
  endtask

  initial begin
    rst_n = 1'b0; wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;
    step(); step();
    rst_n = 1'b1;
    chk_status("reset", 0);
    step();
    chk_status("idle", 0);

    // Fill 0x00..0x0F, then offer 0xFF while full.
    for (int i = 0; i < DEPTH; i++) begin
      wr_valid = 1'b1; wr_data = DW'(i);
      step();
      chk_status($sformatf("fill%0d", i), i + 1);
    end
    wr_data = 32'hFF;
    step();
    chk_status("full_ignore", DEPTH);
    wr_valid = 1'b0;

    // Drain and check FIFO order; the ignored 0xFF must never appear.
    rd_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      chk($sformatf("drain_data%0d", i), 64'(rd_data), 64'(i));
      step();
      chk_status($sformatf("drain%0d", i), DEPTH - 1 - i);
    end
    // Pop offered while empty with a simultaneous write: only the write lands.
    wr_valid = 1'b1; wr_data = 32'h1234_5678;
    step();
    chk_status("empty_pop_push", 1);
    wr_valid = 1'b0;
    chk("empty_pop_push.data", 64'(rd_data), 64'h1234_5678);
    step();
    chk_status("drain_one", 0);
    rd_ready = 1'b0;

    // First-word fall-through latency.
    wr_valid = 1'b1; wr_data = 32'hA5A5_A5A5;
    step();
    wr_valid = 1'b0;
    chk_status("fwft", 1);
    chk("fwft.data", 64'(rd_data), 64'hA5A5_A5A5);
    rd_ready = 1'b1;
    step();
    rd_ready = 1'b0;
    chk_status("fwft_pop", 0);

    // Occupancy 8, then 40 cycles of push+pop; pointers wrap several times.
    for (int i = 0; i < 8; i++) begin
      wr_valid = 1'b1; wr_data = DW'(100 + i);
      step();
    end
    chk_status("pp_pre", 8);
    rd_ready = 1'b1;
    for (int k = 0; k < 40; k++) begin
      wr_data = DW'(200 + k);
      chk($sformatf("pp_data%0d", k), 64'(rd_data), (k < 8) ? 64'(100 + k) : 64'(200 + k - 8));
      step();
      chk($sformatf("pp_count%0d", k), 64'(count), 64'd8);
    end
    wr_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("pp_tail%0d", k), 64'(rd_data), 64'(232 + k));
      step();
    end
    rd_ready = 1'b0;
    chk_status("pp_done", 0);

    // Reset at occupancy 5 with a write offered in the reset cycle.
    for (int i = 0; i < 5; i++) begin
      wr_valid = 1'b1; wr_data = DW'(50 + i);
      step();
    end
    chk_status("rst_pre", 5);
    rst_n = 1'b0; wr_data = 32'hDEAD_BEEF;
    step();
    rst_n = 1'b1; wr_valid = 1'b0;
    chk_status("rst_mid", 0);
    step();
    chk_status("rst_after", 0);

    // Post-reset write lands at slot 0 and reads back correctly.
    wr_valid = 1'b1; wr_data = 32'h0BAD_F00D;
    step();
    wr_valid = 1'b0;
    chk_status("rst_rewrite", 1);
    chk("rst_rewrite.data", 64'(rd_data), 64'h0BAD_F00D);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
